vector_regfile_param: RTL
=========================

VECTOR_REGFILE_PARAM -- requirements
Module: vector_regfile_param

Interface
REQ-001 SHALL have parameter DW, default 32: element and scalar data width.
REQ-002 SHALL have parameter NSREG, default 32: scalar register count; SAW = clog2(NSREG).
REQ-003 SHALL have parameter NVREG, default 4: vector register count; VAW = clog2(NVREG).
REQ-004 SHALL have parameter LANES, default 8: elements per vector register; LW = clog2(LANES+1).
REQ-005 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_raddr1/s_raddr2  in  SAW  scalar read addresses.
- s_rdata1/s_rdata2  out  DW  registered scalar read data.
- s_we, s_waddr, s_wdata  in  1/SAW/DW  scalar write.
- vlen_we, vlen_wdata  in  1/LW  vector-length register write.
- vlen  out  LW  current effective vlen.
- v_raddr1/v_raddr2  in  VAW  vector read addresses.
- v_rdata1/v_rdata2  out  LANES*DW  registered vector read data, lane 0 in LSBs.
- v_we, v_waddr, v_wdata  in  1/VAW/LANES*DW  masked vector write.
- st_start, st_vaddr  in  1/VAW  start element stream of one vector register.
- st_valid, st_data, st_idx  out  1/DW/LW  streamed element, its lane index.
- st_ready  in  1  consumer accepts element.
- st_busy, st_done  out  1/1  stream active; one-cycle completion pulse.

Function
REQ-006 SHALL latch vlen_wdata clamped to LANES when vlen_we=1; vlen output SHALL be the stored value.
REQ-007 SHALL write s_wdata to scalar register s_waddr on clock edge when s_we=1.
REQ-008 SHALL, when v_we=1, write lane i of v_waddr only for i < vlen; lanes >= vlen SHALL keep their value; vlen=0 SHALL write nothing.
REQ-009 SHALL update s_rdata1/2 and v_rdata1/2 every cycle with one-cycle latency from address.
REQ-010 SHALL forward same-cycle writes: scalar read of s_waddr with s_we=1 returns s_wdata; vector read of v_waddr with v_we=1 returns v_wdata on lanes < vlen and old data elsewhere.
REQ-011 SHALL apply vlen_we and v_we in the same cycle using the old vlen for masking.
REQ-012 SHALL implement stream FSM with states IDLE, STREAM.
REQ-013 IDLE: st_start=1 SHALL capture st_vaddr and snapshot vlen as len; len=0 SHALL stay IDLE and pulse st_done next cycle; else go STREAM with idx=0.
REQ-014 STREAM: st_valid=1, st_data = lane idx of captured register (current contents, including same-cycle v_we forwarding), st_idx=idx; st_data/st_idx SHALL hold while st_valid=1 and st_ready=0.
REQ-015 On st_valid&st_ready: idx increments; at idx=len-1 FSM SHALL return to IDLE and pulse st_done in the same cycle as the final handshake.
REQ-016 st_start while STREAM SHALL be ignored; st_busy=1 exactly in STREAM.
REQ-017 A vlen_we during STREAM SHALL NOT change the snapshot len.

Reset
REQ-018 rst_n=0 SHALL asynchronously clear all scalar and vector registers, vlen, s_rdata*, v_rdata*, st_data, st_idx to 0, FSM to IDLE, st_valid/st_busy/st_done to 0.
REQ-019 Reset mid-stream SHALL abort without st_done; first post-reset edge SHALL behave as IDLE.

Structure
REQ-020 SHALL place the FSM state enum and default-parameter constants in a shared package vrf_pkg.
REQ-021 SHALL implement the element stream as sub-module vrf_elem_streamer, receiving the selected vector row and emitting the handshake.

Verification
REQ-022 vlen_we=5, v_we to v1 with lanes = 0x10..0x17 -> next-cycle v_rdata1 (v_raddr1=1) lanes 0..4 = 0x10..0x14, lanes 5..7 = 0.
REQ-023 s_we addr 3 data 0xDEADBEEF with s_raddr1=3 same cycle -> s_rdata1=0xDEADBEEF next cycle.
REQ-024 vlen=3, v2 = {0xA0..0xA7}, st_start v2, st_ready=1 -> st_data 0xA0,0xA1,0xA2 on three consecutive cycles, st_done with third, st_busy then 0.
REQ-025 vlen=4 stream with st_ready toggling 1,0,0,1,... -> each element held stable while stalled, exactly 4 handshakes, idx 0..3 in order.
REQ-026 vlen_wdata=12 with LANES=8 -> vlen=8; vlen=0 and st_start -> no st_valid, st_done pulse next cycle.
REQ-027 rst_n asserted at idx=2 of a 6-element stream -> outputs 0 immediately, no st_done, new st_start afterwards streams from idx 0.

Source files
------------

// File: rtl/vrf_pkg.sv
// -----------------------------------------------------------------------------
// vrf_pkg
// Shared definitions for the vector register file:
//   - default values for the width, register-count and lane-count parameters
//   - the two-state enum used by the element-stream FSM
// -----------------------------------------------------------------------------
package vrf_pkg;

    localparam int VRF_DW    = 32;  // element / scalar data width
    localparam int VRF_NSREG = 32;  // scalar register count
    localparam int VRF_NVREG = 4;   // vector register count
    localparam int VRF_LANES = 8;   // elements per vector register

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } st_state_e;

endpackage

// File: rtl/vrf_elem_streamer.sv
// -----------------------------------------------------------------------------
// vrf_elem_streamer
// Streams the first len elements of one vector register over a valid/ready
// handshake. len is a snapshot of vlen that is taken when the stream starts.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   st_start        start request (honoured only in IDLE)
//   st_vaddr        vector register to stream
//   vlen            current vlen, snapshotted on start
//   rd_vaddr        register whose forwarded row the parent must drive on row
//   row             forwarded contents of rd_vaddr, lane 0 in the LSBs
//   st_valid        element present (high exactly while streaming)
//   st_data/st_idx  element value and its lane index
//   st_ready        consumer accepts the element
//   st_busy         stream active
//   st_done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module vrf_elem_streamer
    import vrf_pkg::*;
#(
    parameter int DW    = VRF_DW,
    parameter int LANES = VRF_LANES,
    parameter int VAW   = 2,
    parameter int LW    = 4
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                st_start,
    input  logic [VAW-1:0]      st_vaddr,
    input  logic [LW-1:0]       vlen,
    output logic [VAW-1:0]      rd_vaddr,
    input  logic [LANES*DW-1:0] row,
    output logic                st_valid,
    output logic [DW-1:0]       st_data,
    output logic [LW-1:0]       st_idx,
    input  logic                st_ready,
    output logic                st_busy,
    output logic                st_done
);

    st_state_e      state_reg, state_next;
    logic [VAW-1:0] vaddr_reg, vaddr_next;
    logic [LW-1:0]  len_reg,   len_next;
    logic [LW-1:0]  idx_reg,   idx_next;
    logic [DW-1:0]  data_reg,  data_next;
    logic           done0_reg, done0_next;   // completion of a zero-length stream
    logic           load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            vaddr_reg <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
            done0_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            vaddr_reg <= vaddr_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            done0_reg <= done0_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vaddr_next = vaddr_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        done0_next = 1'b0;
        load       = 1'b0;
        st_valid   = 1'b0;
        st_busy    = 1'b0;
        st_done    = done0_reg;
        // While idle the requested register is looked at so that the first
        // element can be loaded on the start edge; afterwards the captured one.
        rd_vaddr   = (state_reg == ST_IDLE) ? st_vaddr : vaddr_reg;

        case (state_reg)
            ST_IDLE: begin
                if (st_start) begin
                    vaddr_next = st_vaddr;
                    len_next   = vlen;
                    if (vlen == '0) begin
                        done0_next = 1'b1;
                    end else begin
                        state_next = ST_STREAM;
                        idx_next   = '0;
                        load       = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                st_valid = 1'b1;
                st_busy  = 1'b1;
                if (st_ready) begin
                    if (idx_reg == len_reg - LW'(1)) begin
                        state_next = ST_IDLE;
                        st_done    = 1'b1;
                    end else begin
                        idx_next = idx_reg + LW'(1);
                        load     = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // The element is registered, so it stays put during a stall; a new
        // element is only taken from the (forwarded) row on a load.
        for (int i = 0; i < LANES; i++) begin
            if (load && (idx_next == LW'(i))) begin
                data_next = row[i*DW +: DW];
            end
        end
    end

    assign st_data = data_reg;
    assign st_idx  = idx_reg;

endmodule

// File: rtl/vector_regfile_param.sv
// -----------------------------------------------------------------------------
// vector_regfile_param
// Scalar + vector register file with a vector-length register and an element
// streamer.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_raddr1/2, s_rdata1/2     scalar reads, one-cycle latency, write-forwarded
//   s_we, s_waddr, s_wdata     scalar write
//   vlen_we, vlen_wdata, vlen  vector-length register (clamped to LANES)
//   v_raddr1/2, v_rdata1/2     vector reads, one-cycle latency, write-forwarded
//   v_we, v_waddr, v_wdata     vector write, only lanes below vlen are written
//   st_*                       element stream of one vector register
// -----------------------------------------------------------------------------
module vector_regfile_param
    import vrf_pkg::*;
#(
    parameter  int DW    = VRF_DW,
    parameter  int NSREG = VRF_NSREG,
    parameter  int NVREG = VRF_NVREG,
    parameter  int LANES = VRF_LANES,
    localparam int SAW   = $clog2(NSREG),
    localparam int VAW   = $clog2(NVREG),
    localparam int LW    = $clog2(LANES + 1),
    localparam int VW    = LANES * DW
)(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [SAW-1:0] s_raddr1,
    input  logic [SAW-1:0] s_raddr2,
    output logic [DW-1:0]  s_rdata1,
    output logic [DW-1:0]  s_rdata2,
    input  logic           s_we,
    input  logic [SAW-1:0] s_waddr,
    input  logic [DW-1:0]  s_wdata,
    input  logic           vlen_we,
    input  logic [LW-1:0]  vlen_wdata,
    output logic [LW-1:0]  vlen,
    input  logic [VAW-1:0] v_raddr1,
    input  logic [VAW-1:0] v_raddr2,
    output logic [VW-1:0]  v_rdata1,
    output logic [VW-1:0]  v_rdata2,
    input  logic           v_we,
    input  logic [VAW-1:0] v_waddr,
    input  logic [VW-1:0]  v_wdata,
    input  logic           st_start,
    input  logic [VAW-1:0] st_vaddr,
    output logic           st_valid,
    output logic [DW-1:0]  st_data,
    output logic [LW-1:0]  st_idx,
    input  logic           st_ready,
    output logic           st_busy,
    output logic           st_done
);

    localparam logic [LW-1:0] VLEN_MAX = LW'(LANES);

    logic [DW-1:0]  sreg [NSREG];
    logic [VW-1:0]  vreg [NVREG];
    logic [LW-1:0]  vlen_reg;
    logic [LANES-1:0] lane_en;
    logic [VW-1:0]  fwd_row1, fwd_row2, st_row;
    logic [VAW-1:0] st_rd_vaddr;

    assign vlen = vlen_reg;

    // ---------------- vlen register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vlen_reg <= '0;
        end else if (vlen_we) begin
            vlen_reg <= (vlen_wdata > VLEN_MAX) ? VLEN_MAX : vlen_wdata;
        end
    end

    // ---------------- scalar registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NSREG; r++) sreg[r] <= '0;
        end else if (s_we) begin
            sreg[s_waddr] <= s_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rdata1 <= '0;
            s_rdata2 <= '0;
        end else begin
            s_rdata1 <= (s_we && (s_waddr == s_raddr1)) ? s_wdata : sreg[s_raddr1];
            s_rdata2 <= (s_we && (s_waddr == s_raddr2)) ? s_wdata : sreg[s_raddr2];
        end
    end

    // ---------------- vector registers ----------------
    // Lane enables come from the stored vlen, so a vlen write in the same
    // cycle only affects later vector writes.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_en[gi] = (LW'(gi) < vlen_reg);

            assign fwd_row1[gi*DW +: DW] =
                (v_we && (v_waddr == v_raddr1) && lane_en[gi]) ?
                v_wdata[gi*DW +: DW] : vreg[v_raddr1][gi*DW +: DW];

            assign fwd_row2[gi*DW +: DW] =
                (v_we && (v_waddr == v_raddr2) && lane_en[gi]) ?
                v_wdata[gi*DW +: DW] : vreg[v_raddr2][gi*DW +: DW];

            assign st_row[gi*DW +: DW] =
                (v_we && (v_waddr == st_rd_vaddr) && lane_en[gi]) ?
                v_wdata[gi*DW +: DW] : vreg[st_rd_vaddr][gi*DW +: DW];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NVREG; r++) vreg[r] <= '0;
        end else if (v_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_en[i]) vreg[v_waddr][i*DW +: DW] <= v_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_rdata1 <= '0;
            v_rdata2 <= '0;
        end else begin
            v_rdata1 <= fwd_row1;
            v_rdata2 <= fwd_row2;
        end
    end

    // ---------------- element streamer ----------------
    vrf_elem_streamer #(
        .DW    (DW),
        .LANES (LANES),
        .VAW   (VAW),
        .LW    (LW)
    ) u_streamer (
        .clk      (clk),
        .rst_n    (rst_n),
        .st_start (st_start),
        .st_vaddr (st_vaddr),
        .vlen     (vlen_reg),
        .rd_vaddr (st_rd_vaddr),
        .row      (st_row),
        .st_valid (st_valid),
        .st_data  (st_data),
        .st_idx   (st_idx),
        .st_ready (st_ready),
        .st_busy  (st_busy),
        .st_done  (st_done)
    );

endmodule
